curtain_step_ctrl: RTL
======================

# curtain_step_ctrl

Position controller for the curtain stepper: accepts a target curtain position (in half-steps), compares it with the tracked current position, and emits direction plus one-cycle step pulses at a fixed rate. It sits directly upstream of the phase sequencers, which advance their 4-bit coil pattern by one entry per step pulse in the indicated direction. A step-pulse count provides open-loop position tracking; no motor feedback exists.

## Interface
- POS_W, 12 — width of position/target.
- MAX_POS, 2048 — fully-open position; targets above it are clamped to MAX_POS.
- DIV, 50000 — clk cycles per step (step rate); DIV ≥ 2.
- SETUP, 16 — clk cycles dir is held stable before the first step of a move; SETUP ≥ 1.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  target command offered.
- cmd_ready  out  1  high only in IDLE; a command transfers on a clk edge with cmd_valid && cmd_ready.
- cmd_pos  in  POS_W  requested target position.
- abort  in  1  level; terminates the current move without further steps.
- step  out  1  one-cycle step pulse to the phase sequencer.
- dir  out  1  1 = open (position increments), 0 = close (position decrements).
- pos  out  POS_W  current tracked position.
- busy  out  1  high in SETTLE and RUN.
- done  out  1  one-cycle pulse when a command completes or is aborted.

## Operation
- FSM states: IDLE, SETTLE, RUN, DONE.
- IDLE: cmd_ready=1. On transfer: tgt ← min(cmd_pos, MAX_POS). If tgt == pos, go to DONE. Otherwise, dir ← (tgt > pos), clear the settle counter, and go to SETTLE.
- SETTLE: count SETUP cycles with no steps, then go to RUN with the rate counter cleared.
- RUN: the rate counter counts 0..DIV-1. On the edge where it wraps, step is high for the following cycle and pos ±1 on that same edge. After a step that makes pos == tgt, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- abort in SETTLE or RUN: go to DONE on the next edge with no step. An abort coinciding with a rate-counter wrap wins: no step, pos unchanged. abort in IDLE or DONE is ignored.
- dir changes only on command acceptance; it is never changed while busy.
- pos saturates: it never decrements below 0 or increments above MAX_POS. A step that would violate this is suppressed and forces DONE.
- cmd_valid in any state other than IDLE is not accepted. The command is held by the producer.
- Reset (any state, mid-move included): state=IDLE, pos=0, tgt=0, step=0, dir=0, busy=0, done=0, counters=0. cmd_ready=1 because it is decoded from IDLE. The power-up position is defined as fully closed.

## Timing
- All outputs except cmd_ready are registered. cmd_ready = (state == IDLE).
- Command accepted at edge E:
  - busy and dir are valid from E+1.
  - SETTLE occupies cycles E+1 … E+SETUP.
  - The first step is high in the cycle after edge E+SETUP+DIV.
- The gap between consecutive step pulses is exactly DIV cycles, edge to edge.
- A move of k steps ends as follows:
  - The last step pulse is at cycle E+SETUP+k·DIV+1.
  - done is high in the next cycle, with busy low in that same cycle.
  - cmd_ready is high one cycle after done.
- Zero-length command: done is high at E+1 and cmd_ready is high at E+2.
- Abort sampled at edge A: done is high at A+1, and step stays low from A+1 onward.

## Structure
- Shared package curtain_pkg holds:
  - the state enum {IDLE, SETTLE, RUN, DONE};
  - DIR_OPEN=1 and DIR_CLOSE=0;
  - the default POS_W and MAX_POS, also used by the phase sequencers and light-compare logic.
- One sub-module: step_rate_div, a parameterised DIV counter with clear and enable that outputs a one-cycle wrap tick. The FSM, position counter, clamp and saturation stay in the top.

## Test plan
All scenarios use DIV=4, SETUP=2, MAX_POS=2048.
- Reset, then cmd_pos=3 accepted at edge E → dir=1 at E+1; step at E+7, E+11, E+15; pos 1,2,3; done at E+16; cmd_ready at E+17.
- From pos=3, cmd_pos=1 → dir=0 at E+1; two steps 4 cycles apart; pos 2,1; done one cycle after the second step.
- cmd_pos equal to current pos → no step, done at E+1, busy never high.
- cmd_pos=4000 from pos=2046 → clamped to 2048; exactly 2 steps; pos=2048; done.
- abort asserted on the same cycle as a rate-counter wrap during RUN → no step, pos unchanged, done the next cycle; a new command is accepted afterwards.
- rst_n pulsed low mid-RUN → all outputs are at reset values immediately (asynchronously); pos=0; state IDLE; the next command starts cleanly with SETTLE.

Source files
------------

// File: rtl/curtain_pkg.sv
// rtl/curtain_pkg.sv - shared types and defaults for the curtain stepper blocks
package curtain_pkg;

  // Default geometry, shared with the phase sequencers and light-compare logic
  localparam int POS_W_DEF   = 12;
  localparam int MAX_POS_DEF = 2048;

  // Direction encoding: open moves position up, close moves it down
  localparam logic DIR_OPEN  = 1'b1;
  localparam logic DIR_CLOSE = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/step_rate_div.sv
// rtl/step_rate_div.sv - step rate divider with clear/enable and wrap tick
module step_rate_div #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Tick on the last count of the period so the caller acts on the wrap edge
  assign tick = en && (cnt_q == CW'(DIV - 1));

  // Next count: clear wins, otherwise advance and wrap at DIV-1
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/curtain_step_ctrl.sv
// rtl/curtain_step_ctrl.sv - curtain position controller issuing step pulses
module curtain_step_ctrl
  import curtain_pkg::*;
#(
  parameter int POS_W   = POS_W_DEF,
  parameter int MAX_POS = MAX_POS_DEF,
  parameter int DIV     = 50000,
  parameter int SETUP   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [POS_W-1:0] cmd_pos,
  input  logic             abort,
  output logic             step,
  output logic             dir,
  output logic [POS_W-1:0] pos,
  output logic             busy,
  output logic             done
);

  localparam int               SCW   = $clog2(SETUP + 1);
  localparam logic [POS_W-1:0] MAX_P = POS_W'(MAX_POS);

  state_e           state_q, state_d;
  logic [POS_W-1:0] tgt_q, tgt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [SCW-1:0]   set_cnt_q, set_cnt_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [POS_W-1:0] clamp_pos;
  logic             rate_tick;
  logic             at_limit;

  // Rate counter runs only in RUN and sits at zero otherwise
  step_rate_div #(.DIV(DIV)) u_rate (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != RUN),
    .en    (state_q == RUN),
    .tick  (rate_tick)
  );

  assign clamp_pos = (cmd_pos > MAX_P) ? MAX_P : cmd_pos;
  assign at_limit  = (dir_q == DIR_OPEN) ? (pos_q >= MAX_P) : (pos_q == '0);

  assign cmd_ready = (state_q == IDLE);
  assign step      = step_q;
  assign dir       = dir_q;
  assign pos       = pos_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Next-state and registered-output decode for the move sequencer
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    pos_d     = pos_q;
    set_cnt_d = set_cnt_q;
    dir_d     = dir_q;
    step_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (cmd_valid) begin
          tgt_d = clamp_pos;
          if (clamp_pos == pos_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            dir_d     = (clamp_pos > pos_q) ? DIR_OPEN : DIR_CLOSE;
            set_cnt_d = '0;
            busy_d    = 1'b1;
            state_d   = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (set_cnt_q == SCW'(SETUP - 1)) begin
          state_d = RUN;
        end else begin
          set_cnt_d = set_cnt_q + SCW'(1);
        end
      end
      RUN: begin
        // Abort and arrival both end the move; abort also swallows a coincident wrap
        if (abort || (pos_q == tgt_q)) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (rate_tick) begin
          if (at_limit) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            step_d = 1'b1;
            pos_d  = (dir_q == DIR_OPEN) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset defines the closed position as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tgt_q     <= '0;
      pos_q     <= '0;
      set_cnt_q <= '0;
      dir_q     <= DIR_CLOSE;
      step_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      pos_q     <= pos_d;
      set_cnt_q <= set_cnt_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule
